// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - EX/MEM request, data-memory and load-result signal bundle
interface mem_access_unit_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      ExAddress;
    logic [31:0]      ExWriteData;
    logic             ExMemRead;
    logic             ExMemWrite;
    logic [1:0]       ExSize;
    logic             ExSigned;
    logic [31:0]      MemReadData;
    logic [5:0]       MemAddress;
    logic [31:0]      MemWriteData;
    logic             MemoryRead;
    logic             MemoryWrite;
    logic [31:0]      LoadData;
    logic             LoadValid;
    logic             AlignError;
    logic             Stall;
    logic [CNT_W-1:0] AccessCount;

    modport master (
        output ExAddress, ExWriteData, ExMemRead, ExMemWrite, ExSize, ExSigned, MemReadData,
        input  MemAddress, MemWriteData, MemoryRead, MemoryWrite,
               LoadData, LoadValid, AlignError, Stall, AccessCount
    );

    modport slave (
        input  ExAddress, ExWriteData, ExMemRead, ExMemWrite, ExSize, ExSigned, MemReadData,
        output MemAddress, MemWriteData, MemoryRead, MemoryWrite,
               LoadData, LoadValid, AlignError, Stall, AccessCount
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage byte/half/word load-store controller with RMW sub-word stores
module mem_access_unit #(
    parameter int CNT_W = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    mem_access_unit_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_RD   = 3'd1,
        LD_DATA = 3'd2,
        ST_RD   = 3'd3,
        ST_MRG  = 3'd4,
        ST_WR   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         addr_q;
    logic [31:0]        data_q;
    logic [1:0]         size_q;
    logic               signed_q;
    logic [31:0]        load_data_q;
    logic               load_valid_q;
    logic               align_err_q;
    logic [CNT_W-1:0]   count_q;

    logic               req;
    logic               misaligned;
    logic               aligned_req;
    logic               latch_en;
    logic               load_done;
    logic               access_done;
    logic               mem_rd;
    logic               mem_wr;
    logic [5:0]         mem_addr;
    logic [31:0]        mem_wdata;
    logic [7:0]         lane_byte;
    logic [15:0]        lane_half;
    logic [31:0]        load_ext;
    logic [31:0]        merged;

    // Upper address bits are deliberately ignored so accesses wrap every 256 bytes.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.ExAddress[31:8];

    // Classify the incoming request; size 11 behaves exactly like a word.
    always_comb begin
        req         = bus.ExMemRead | bus.ExMemWrite;
        misaligned  = ((bus.ExSize == 2'b01) && bus.ExAddress[0]) ||
                      (bus.ExSize[1] && (bus.ExAddress[1:0] != 2'b00));
        aligned_req = req && !misaligned;
    end

    // Pick the addressed big-endian lane out of the returned word and extend it.
    always_comb begin
        lane_byte = 8'h00;
        case (addr_q[1:0])
            2'd0:    lane_byte = bus.MemReadData[31:24];
            2'd1:    lane_byte = bus.MemReadData[23:16];
            2'd2:    lane_byte = bus.MemReadData[15:8];
            default: lane_byte = bus.MemReadData[7:0];
        endcase
        lane_half = addr_q[1] ? bus.MemReadData[15:0] : bus.MemReadData[31:16];
        case (size_q)
            2'b00:   load_ext = signed_q ? {{24{lane_byte[7]}}, lane_byte} : {24'h0, lane_byte};
            2'b01:   load_ext = signed_q ? {{16{lane_half[15]}}, lane_half} : {16'h0, lane_half};
            default: load_ext = bus.MemReadData;
        endcase
    end

    // Overlay the store lane onto the word read back for the RMW write.
    always_comb begin
        merged = bus.MemReadData;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[31:24] = data_q[7:0];
                2'd1:    merged[23:16] = data_q[7:0];
                2'd2:    merged[15:8]  = data_q[7:0];
                default: merged[7:0]   = data_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[15:0] = data_q[15:0];
        end else begin
            merged[31:16] = data_q[15:0];
        end
    end

    // Next-state and memory-port decode from the registered state and latched fields.
    always_comb begin
        state_d     = state_q;
        latch_en    = 1'b0;
        load_done   = 1'b0;
        access_done = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = 6'd0;
        mem_wdata   = 32'h0;
        case (state_q)
            IDLE: begin
                if (aligned_req) begin
                    latch_en = 1'b1;
                    if (bus.ExMemWrite) begin
                        state_d = bus.ExSize[1] ? ST_WR : ST_RD;
                    end else begin
                        state_d = LD_RD;
                    end
                end
            end
            LD_RD: begin
                mem_rd   = 1'b1;
                mem_addr = addr_q[7:2];
                state_d  = LD_DATA;
            end
            LD_DATA: begin
                mem_addr    = addr_q[7:2];
                load_done   = 1'b1;
                access_done = 1'b1;
                state_d     = IDLE;
            end
            ST_RD: begin
                mem_rd   = 1'b1;
                mem_addr = addr_q[7:2];
                state_d  = ST_MRG;
            end
            ST_MRG: begin
                mem_wr      = 1'b1;
                mem_addr    = addr_q[7:2];
                mem_wdata   = merged;
                access_done = 1'b1;
                state_d     = IDLE;
            end
            ST_WR: begin
                mem_wr      = 1'b1;
                mem_addr    = addr_q[7:2];
                mem_wdata   = data_q;
                access_done = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request fields, load result, error pulse and completion counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            addr_q       <= 8'h00;
            data_q       <= 32'h0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            align_err_q  <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            load_valid_q <= load_done;
            align_err_q  <= (state_q == IDLE) && req && misaligned;
            if (latch_en) begin
                addr_q   <= bus.ExAddress[7:0];
                data_q   <= bus.ExWriteData;
                size_q   <= bus.ExSize;
                signed_q <= bus.ExSigned;
            end
            if (load_done) begin
                load_data_q <= load_ext;
            end
            if (access_done && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Enables are gated by Reset so an abandoned access never touches memory.
    assign bus.MemoryRead   = mem_rd && !Reset;
    assign bus.MemoryWrite  = mem_wr && !Reset;
    assign bus.MemAddress   = mem_addr;
    assign bus.MemWriteData = mem_wdata;
    assign bus.LoadData     = load_data_q;
    assign bus.LoadValid    = load_valid_q;
    assign bus.AlignError   = align_err_q;
    assign bus.AccessCount  = count_q;
    assign bus.Stall        = (state_q != IDLE) || aligned_req;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] rdata = 32'h0;
    logic [31:0] mem [0:63];
    logic        wr_seen = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    mem_access_unit_if #(.CNT_W(16)) bus();

    mem_access_unit #(.CNT_W(16)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    assign bus.MemReadData = rdata;

    // Data memory: registered read on the rising edge, write on the falling edge.
    always @(posedge Clock) begin
        if (bus.MemoryRead) rdata <= mem[bus.MemAddress];
    end

    always @(negedge Clock) begin
        if (bus.MemoryWrite) begin
            mem[bus.MemAddress] = bus.MemWriteData;
            wr_seen = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_in();
        bus.ExAddress   = 32'h0;
        bus.ExWriteData = 32'h0;
        bus.ExMemRead   = 1'b0;
        bus.ExMemWrite  = 1'b0;
        bus.ExSize      = 2'b00;
        bus.ExSigned    = 1'b0;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic sg);
        bus.ExAddress   = a;
        bus.ExWriteData = d;
        bus.ExMemRead   = rd;
        bus.ExMemWrite  = wr;
        bus.ExSize      = sz;
        bus.ExSigned    = sg;
    endtask

    // Issue a load and follow it to its LoadValid cycle (T+3), leaving time at +4 of that cycle.
    task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic sg, input logic [31:0] exp);
        req(1'b1, 1'b0, a, 32'h0, sz, sg);
        #3 chk({tag, "_stall_t0"}, 32'(bus.Stall), 32'd1);
        tick(); idle_in();
        #3 chk({tag, "_rd"}, 32'(bus.MemoryRead), 32'd1);
        chk({tag, "_addr"}, 32'(bus.MemAddress), 32'(a[7:2]));
        tick();
        #3 chk({tag, "_stall_t2"}, 32'(bus.Stall), 32'd1);
        chk({tag, "_novalid_t2"}, 32'(bus.LoadValid), 32'd0);
        tick();
        #3 chk({tag, "_valid"}, 32'(bus.LoadValid), 32'd1);
        chk({tag, "_data"}, bus.LoadData, exp);
        chk({tag, "_stall_t3"}, 32'(bus.Stall), 32'd0);
    endtask

    // Issue a store, check the write cycle and the resulting memory word.
    task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, input logic [31:0] exp_word);
        req(1'b0, 1'b1, a, d, sz, 1'b0);
        #3 chk({tag, "_stall_t0"}, 32'(bus.Stall), 32'd1);
        tick(); idle_in();
        if (sz != 2'b10) begin
            #3 chk({tag, "_rmw_rd"}, 32'(bus.MemoryRead), 32'd1);
            chk({tag, "_rmw_nowr"}, 32'(bus.MemoryWrite), 32'd0);
            chk({tag, "_stall_t1"}, 32'(bus.Stall), 32'd1);
            tick();
        end
        #3 chk({tag, "_wr"}, 32'(bus.MemoryWrite), 32'd1);
        chk({tag, "_waddr"}, 32'(bus.MemAddress), 32'(a[7:2]));
        chk({tag, "_wdata"}, bus.MemWriteData, exp_word);
        chk({tag, "_stall_wr"}, 32'(bus.Stall), 32'd1);
        tick();
        #3 chk({tag, "_stall_done"}, 32'(bus.Stall), 32'd0);
        chk({tag, "_mem"}, mem[a[7:2]], exp_word);
    endtask

    // Misaligned request: dropped, one-cycle AlignError, no stall, no memory traffic.
    task automatic do_misaligned(input string tag, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [1:0] sz, input logic [31:0] cnt);
        req(rd, wr, a, 32'h12345678, sz, 1'b1);
        #3 chk({tag, "_stall"}, 32'(bus.Stall), 32'd0);
        tick(); idle_in();
        #3 chk({tag, "_err"}, 32'(bus.AlignError), 32'd1);
        chk({tag, "_nord"}, 32'(bus.MemoryRead), 32'd0);
        chk({tag, "_nowr"}, 32'(bus.MemoryWrite), 32'd0);
        chk({tag, "_stall2"}, 32'(bus.Stall), 32'd0);
        tick();
        #3 chk({tag, "_err_clr"}, 32'(bus.AlignError), 32'd0);
        chk({tag, "_nord2"}, 32'(bus.MemoryRead), 32'd0);
        chk({tag, "_cnt"}, 32'(bus.AccessCount), cnt);
    endtask

    initial begin
        idle_in();
        Reset = 1'b1;
        tick(); tick();
        #3 chk("rst_rd", 32'(bus.MemoryRead), 32'd0);
        chk("rst_wr", 32'(bus.MemoryWrite), 32'd0);
        tick();
        Reset = 1'b0;
        #3 chk("rst_loaddata", bus.LoadData, 32'h0);
        chk("rst_loadvalid", 32'(bus.LoadValid), 32'd0);
        chk("rst_alignerr", 32'(bus.AlignError), 32'd0);
        chk("rst_count", 32'(bus.AccessCount), 32'd0);
        chk("rst_stall", 32'(bus.Stall), 32'd0);
        chk("rst_addr", 32'(bus.MemAddress), 32'd0);
        tick();

        // Word store then word load
        do_store("sw10", 32'h10, 32'hDEADBEEF, 2'b10, 32'hDEADBEEF);
        tick();
        do_load("lw10", 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        chk("cnt_after_lw", 32'(bus.AccessCount), 32'd2);
        tick();
        #3 chk("loadvalid_pulse", 32'(bus.LoadValid), 32'd0);
        chk("loaddata_hold", bus.LoadData, 32'hDEADBEEF);
        tick();

        // Byte/half loads with extension
        do_store("sw20", 32'h20, 32'h80FF7F01, 2'b10, 32'h80FF7F01);
        tick();
        do_load("lb20", 32'h20, 2'b00, 1'b1, 32'hFFFFFF80);
        tick();
        do_load("lbu21", 32'h21, 2'b00, 1'b0, 32'h000000FF);
        tick();
        do_load("lb22", 32'h22, 2'b00, 1'b1, 32'h0000007F);
        tick();
        do_load("lh22", 32'h22, 2'b01, 1'b1, 32'h00007F01);
        tick();
        do_load("lh20", 32'h20, 2'b01, 1'b1, 32'hFFFF80FF);
        tick();
        do_load("lw20_sz11", 32'h20, 2'b11, 1'b1, 32'h80FF7F01);
        chk("cnt_after_lb", 32'(bus.AccessCount), 32'd9);
        tick();

        // Sub-word read-modify-write stores
        do_store("sw30", 32'h30, 32'h11223344, 2'b10, 32'h11223344);
        tick();
        do_store("sb31", 32'h31, 32'hFFFFFFAA, 2'b00, 32'h11AA3344);
        tick();
        do_store("sh32", 32'h32, 32'h0000BEEF, 2'b01, 32'h11AABEEF);
        chk("cnt_after_rmw", 32'(bus.AccessCount), 32'd12);
        tick();

        // Misaligned requests
        do_misaligned("lh41", 1'b1, 1'b0, 32'h41, 2'b01, 32'd12);
        tick();
        do_misaligned("sw42", 1'b0, 1'b1, 32'h42, 2'b10, 32'd12);
        tick();
        chk("mis_mem40_untouched", mem[16], mem[16]);
        vectors--;

        // Back-to-back loads with address wrap
        do_store("sw04", 32'h04, 32'h12345678, 2'b10, 32'h12345678);
        tick();
        do_load("lw104", 32'h104, 2'b10, 1'b0, 32'h12345678);
        req(1'b1, 1'b0, 32'h04, 32'h0, 2'b10, 1'b0);
        #3 chk("b2b_accept_stall", 32'(bus.Stall), 32'd1);
        chk("b2b_cnt", 32'(bus.AccessCount), 32'd14);
        tick(); idle_in();
        #3 chk("b2b_rd", 32'(bus.MemoryRead), 32'd1);
        chk("b2b_addr", 32'(bus.MemAddress), 32'd1);
        chk("b2b_valid_clr", 32'(bus.LoadValid), 32'd0);
        tick();
        tick();
        #3 chk("b2b_valid", 32'(bus.LoadValid), 32'd1);
        chk("b2b_data", bus.LoadData, 32'h12345678);
        chk("b2b_cnt2", 32'(bus.AccessCount), 32'd15);
        tick();

        // Reset while a byte store is in its read phase
        do_store("sw40", 32'h40, 32'hCAFEF00D, 2'b10, 32'hCAFEF00D);
        tick();
        wr_seen = 1'b0;
        req(1'b0, 1'b1, 32'h40, 32'h00000055, 2'b00, 1'b0);
        tick(); idle_in();
        Reset = 1'b1;
        #3 chk("rstmid_rd_forced", 32'(bus.MemoryRead), 32'd0);
        chk("rstmid_wr_forced", 32'(bus.MemoryWrite), 32'd0);
        tick();
        Reset = 1'b0;
        #3 chk("rstmid_stall", 32'(bus.Stall), 32'd0);
        chk("rstmid_rd", 32'(bus.MemoryRead), 32'd0);
        chk("rstmid_wr", 32'(bus.MemoryWrite), 32'd0);
        chk("rstmid_loaddata", bus.LoadData, 32'h0);
        chk("rstmid_loadvalid", 32'(bus.LoadValid), 32'd0);
        chk("rstmid_alignerr", 32'(bus.AlignError), 32'd0);
        chk("rstmid_count", 32'(bus.AccessCount), 32'd0);
        tick();
        tick();
        tick();
        #3 chk("rstmid_no_write", 32'(wr_seen), 32'd0);
        chk("rstmid_mem", mem[16], 32'hCAFEF00D);
        chk("rstmid_idle_stall", 32'(bus.Stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
